led_bar_ctrl: RTL



---
 rtl/led_bar_pkg.sv | 17 +
 rtl/led_bar_ctrl_if.sv | 12 +
 rtl/pb_debounce.sv | 38 +++
 rtl/led_bar_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/led_bar_pkg.sv
// Shared definitions for the LED bar front-end: FSM state encoding and width.
package led_bar_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    UP_HOLD = 2'b01,
    DN_HOLD = 2'b10,
    LOCK    = 2'b11
  } bar_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_bar_ctrl_if.sv
// Command/status link between the button controller and the bar register.
interface led_bar_ctrl_if;

  logic step_up;
  logic step_dn;
  logic bar_full;
  logic bar_empty;

  modport master (output step_up, output step_dn, input bar_full, input bar_empty);
  modport slave  (input step_up, input step_dn, output bar_full, output bar_empty);

endinterface

// File: rtl/pb_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low pushbutton.
module pb_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // The level flips one cycle after the counter reaches DEBOUNCE_CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      db      <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_p0 <= pb;
      sync_p1 <= sync_p0;
      if (sync_p1 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC)) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_bar_ctrl.sv
// Button front-end for the 8-LED fill/drain bar: debounce, arbitration, step pulses.
// Hold-to-repeat is built only when AUTO_REPEAT_EN is defined.
module led_bar_ctrl
  import led_bar_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pb1,
  input  logic                 pb2,
  led_bar_ctrl_if.master       bar,
  output logic [STATE_W-1:0]   state_o
);

  logic       db_pb1;
  logic       db_pb2;
  logic       up_p;
  logic       dn_p;
  bar_state_t state;
  logic       step_up_r;
  logic       step_dn_r;

  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .pb    (pb1),
    .db    (db_pb1)
  );

  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk   (clk),
    .rst_n (rst_n),
    .pb    (pb2),
    .db    (db_pb2)
  );

  assign up_p = ~db_pb2;
  assign dn_p = ~db_pb1;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(imax(REPEAT_DLY, REPEAT_PER) + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             rep_hit;

  // First repeat waits the long delay, later ones the short period.
  assign rep_hit = rep_first ? (rep_cnt == REP_W'(REPEAT_DLY - 1))
                             : (rep_cnt == REP_W'(REPEAT_PER - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_up_r <= 1'b0;
      step_dn_r <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      step_up_r <= 1'b0;
      step_dn_r <= 1'b0;
`ifdef AUTO_REPEAT_EN
      // Timer idles at zero unless a hold persists, so entry and exit both clear it.
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (up_p && dn_p) begin
            state <= LOCK;
          end else if (up_p) begin
            state     <= UP_HOLD;
            step_up_r <= ~bar.bar_full;
          end else if (dn_p) begin
            state     <= DN_HOLD;
            step_dn_r <= ~bar.bar_empty;
          end
        end
        UP_HOLD: begin
          if (dn_p) begin
            state <= LOCK;
          end else if (!up_p) begin
            state <= IDLE;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (rep_hit) begin
              step_up_r <= ~bar.bar_full;
              rep_first <= 1'b0;
            end else begin
              rep_cnt   <= rep_cnt + REP_W'(1);
              rep_first <= rep_first;
            end
`endif
          end
        end
        DN_HOLD: begin
          if (up_p) begin
            state <= LOCK;
          end else if (!dn_p) begin
            state <= IDLE;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (rep_hit) begin
              step_dn_r <= ~bar.bar_empty;
              rep_first <= 1'b0;
            end else begin
              rep_cnt   <= rep_cnt + REP_W'(1);
              rep_first <= rep_first;
            end
`endif
          end
        end
        LOCK: begin
          if (!up_p && !dn_p) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bar.step_up = step_up_r;
  assign bar.step_dn = step_dn_r;
  assign state_o     = state;

endmodule
